// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC sequencing FSM (IDLE/RUN/STALL/FLUSH/HALT).
// Optional macro PC_SEQUENCER_INSTRET_EN adds a saturating instret counter.
module pc_sequencer #(
   parameter int MEM_DEPTH    = 1024,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] pc_cur,
   output logic        pc_load,
   output logic [31:0] pc_next,
   output logic        flush,
   output logic        halted,
`ifdef PC_SEQUENCER_INSTRET_EN
   output logic        bad_target,
   output logic [31:0] instret
`else
   output logic        bad_target
`endif
);

   localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);
   localparam logic [31:0] LAST  = 32'(MEM_DEPTH - 1);
   localparam logic [2:0]  FLOAD = 3'(FLUSH_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_STALL,
      S_FLUSH,
      S_HALT
   } state_t;

   state_t      state_q;
   logic        load_q;
   logic [31:0] next_q;
   logic        flush_q;
   logic        halt_q;
   logic        bad_q;
   logic [2:0]  cnt_q;

   // Sequencer FSM; every output is a register written here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         load_q  <= 1'b0;
         next_q  <= '0;
         flush_q <= 1'b0;
         halt_q  <= 1'b0;
         bad_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               flush_q <= 1'b0;
               if (start) begin
                  state_q <= S_RUN;
                  load_q  <= 1'b1;
                  next_q  <= '0;
               end else begin
                  load_q  <= 1'b0;
               end
            end
            // STALL with stall low behaves exactly like RUN.
            S_RUN, S_STALL: begin
               flush_q <= 1'b0;
               if (stall) begin
                  state_q <= S_STALL;
                  load_q  <= 1'b0;
               end else if (branch_taken) begin
                  if (branch_target < DEPTH) begin
                     state_q <= S_FLUSH;
                     load_q  <= 1'b1;
                     next_q  <= branch_target;
                     flush_q <= 1'b1;
                     cnt_q   <= FLOAD;
                  end else begin
                     state_q <= S_HALT;
                     load_q  <= 1'b0;
                     halt_q  <= 1'b1;
                     bad_q   <= 1'b1;
                  end
               end else if (pc_cur < LAST) begin
                  state_q <= S_RUN;
                  load_q  <= 1'b1;
                  next_q  <= pc_cur + 32'd1;
               end else begin
                  state_q <= S_HALT;
                  load_q  <= 1'b0;
                  next_q  <= LAST;
                  halt_q  <= 1'b1;
               end
            end
            S_FLUSH: begin
               load_q <= 1'b1;
               next_q <= pc_cur + 32'd1;
               if (cnt_q == 3'd0) begin
                  state_q <= S_RUN;
                  flush_q <= 1'b0;
               end else begin
                  flush_q <= 1'b1;
                  cnt_q   <= cnt_q - 3'd1;
               end
            end
            S_HALT: begin
               load_q  <= 1'b0;
               flush_q <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               load_q  <= 1'b0;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc_load    = load_q;
   assign pc_next    = next_q;
   assign flush      = flush_q;
   assign halted     = halt_q;
   assign bad_target = bad_q;

`ifdef PC_SEQUENCER_INSTRET_EN
   logic [31:0] inst_q;

   // Count cycles that present a real (non-squashed) fetch, saturating.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_q <= '0;
      end else if (load_q && !flush_q && inst_q != 32'hFFFF_FFFF) begin
         inst_q <= inst_q + 32'd1;
      end
   end

   assign instret = inst_q;
`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, meaning instruction memory depth in words; last valid address is MEM_DEPTH-1.
REQ-002 Parameter FLUSH_CYCLES, default 2, meaning bubble cycles inserted after a taken branch (range 1..7).
REQ-003 Port clk  input  1  clock; reset rst, asynchronous, active-low; clock clk.
REQ-004 Port rst  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  level; begin fetching from IDLE.
REQ-006 Port stall  input  1  hold PC this cycle (hazard/memory wait).
REQ-007 Port branch_taken  input  1  redirect request, valid in RUN only.
REQ-008 Port branch_target  input  32  redirect word address.
REQ-009 Port pc_cur  input  32  current PC register value.
REQ-010 Port pc_load  output  1  registered; PC register load enable.
REQ-011 Port pc_next  output  32  registered; value to load into PC.
REQ-012 Port flush  output  1  registered; high while squashing fetched instructions.
REQ-013 Port halted  output  1  registered; high in HALT.
REQ-014 Port bad_target  output  1  registered sticky; branch target out of range.

Function
REQ-015 States SHALL be IDLE, RUN, STALL, FLUSH, HALT; all outputs registered on posedge clk, so inputs sampled at edge N take effect in outputs after edge N.
REQ-016 IDLE: pc_load=0; start=1 -> RUN with pc_load=1, pc_next=0.
REQ-017 RUN priority SHALL be stall > branch_taken > sequential.
REQ-018 RUN, stall=1 -> STALL, pc_load=0, pc_next unchanged.
REQ-019 STALL: remain while stall=1; stall=0 -> RUN, branch_taken then evaluated as in RUN in that same cycle.
REQ-020 RUN, branch_taken=1, branch_target<MEM_DEPTH -> pc_load=1, pc_next=branch_target, flush=1, enter FLUSH with counter loaded to FLUSH_CYCLES-1.
REQ-021 FLUSH: pc_load=1, pc_next=pc_cur+1, flush=1; counter decrements; at 0 -> RUN with flush=0; stall and branch_taken ignored in FLUSH.
REQ-022 RUN sequential: pc_cur<MEM_DEPTH-1 -> pc_load=1, pc_next=pc_cur+1 (32-bit unsigned add).
REQ-023 RUN sequential with pc_cur>=MEM_DEPTH-1 -> HALT, pc_load=0, pc_next=MEM_DEPTH-1; PC never advances past last address.
REQ-024 RUN, branch_taken=1, branch_target>=MEM_DEPTH -> HALT, bad_target=1, pc_load=0.
REQ-025 HALT is terminal; exited only by reset; start ignored.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, pc_load=0, pc_next=0, flush=0, halted=0, bad_target=0, flush counter=0.
REQ-027 Reset mid-FLUSH or mid-STALL SHALL discard pending state; first cycle after release is IDLE.

Configuration
REQ-028 Macro PC_SEQUENCER_INSTRET_EN defined: add output instret (32, registered) counting cycles with pc_load=1 and flush=0, reset to 0, saturating at 32'hFFFFFFFF.
REQ-029 Macro undefined: no instret port, no counter logic; all other behaviour identical.

Verification
REQ-030 Reset, start=1 for one cycle, no stall/branch -> pc_next 0,1,2,... each cycle, pc_load=1, flush=0.
REQ-031 pc_cur=5 in RUN, stall=1 for 3 cycles -> pc_load=0 three cycles, state STALL; stall=0 -> pc_next=6.
REQ-032 pc_cur=10, branch_taken=1, target=200 -> pc_next=200, flush=1 for exactly 2 cycles (default), then sequential 202 with flush=0.
REQ-033 Sequential run to pc_cur=1023 -> halted=1, pc_load=0, pc_next=1023; start pulsed -> stays HALT.
REQ-034 branch_target=1024 -> halted=1, bad_target=1; rst=0 mid-FLUSH -> all outputs 0 immediately, IDLE.
REQ-035 With PC_SEQUENCER_INSTRET_EN: 10 sequential fetches plus one branch with 2 flush cycles -> instret=11.
